pulse_burst_arbiter: RTL

//   Shares one programmable periodic pulse timer among NREQ requesters.
//   A round-robin arbiter grants the timer to one requester at a time and emits

---
 rtl/pulse_burst_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pulse_burst_arbiter.sv
// Round-robin arbiter sharing one periodic pulse timer among NREQ requesters.
// The winner's period and burst length are latched at grant; done flags the end of a burst.
module pulse_burst_arbiter #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 8,
  parameter int LEN_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*CNT_W-1:0]     period,
  input  logic [NREQ*LEN_W-1:0]     length,
  output logic [NREQ-1:0]           grant,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy,
  output logic                      pulse_out,
  output logic [NREQ-1:0]           done
);

  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_d;
  logic [IDX_W-1:0] ptr, ptr_d, owner_d, pick;
  logic             found;
  logic [CNT_W-1:0] cnt, cnt_d, per, per_d, pick_per;
  logic [LEN_W-1:0] left, left_d, pick_len;
  logic [NREQ-1:0]  grant_d, done_d;
  logic             busy_d, pulse_d;
  logic             abort, last;

  // Search starts just after the last owner and wraps, giving round-robin fairness.
  always_comb begin
    int unsigned      idx;
    logic [IDX_W-1:0] sel;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    sel   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      sel = IDX_W'(idx);
      if (!found && req[sel]) begin
        found = 1'b1;
        pick  = sel;
      end
    end
  end

  assign pick_per = period[32'(pick)*CNT_W +: CNT_W];
  assign pick_len = length[32'(pick)*LEN_W +: LEN_W];
  assign abort    = !req[owner];
  assign last     = (cnt == per) && (left == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (found && pick_len != '0) state_d = RUN;
      RUN:     if (abort || last)           state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant;
    owner_d = owner;
    ptr_d   = ptr;
    busy_d  = busy;
    cnt_d   = cnt;
    left_d  = left;
    per_d   = per;
    pulse_d = 1'b0;
    done_d  = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          ptr_d   = pick;
          owner_d = pick;
          if (pick_len == '0) begin
            done_d[pick] = 1'b1;
          end else begin
            grant_d       = '0;
            grant_d[pick] = 1'b1;
            busy_d        = 1'b1;
            cnt_d         = '0;
            left_d        = pick_len;
            per_d         = pick_per;
          end
        end
      end
      RUN: begin
        // Abort outranks a coincident period match: a dropped request gets no further pulse.
        if (abort) begin
          grant_d = '0;
          busy_d  = 1'b0;
        end else if (cnt == per) begin
          cnt_d   = '0;
          pulse_d = 1'b1;
          left_d  = left - LEN_W'(1);
          if (last) begin
            done_d[owner] = 1'b1;
            grant_d       = '0;
            busy_d        = 1'b0;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant     <= '0;
      owner     <= '0;
      ptr       <= IDX_W'(NREQ - 1);
      busy      <= 1'b0;
      cnt       <= '0;
      left      <= '0;
      per       <= '0;
      pulse_out <= 1'b0;
      done      <= '0;
    end else begin
      grant     <= grant_d;
      owner     <= owner_d;
      ptr       <= ptr_d;
      busy      <= busy_d;
      cnt       <= cnt_d;
      left      <= left_d;
      per       <= per_d;
      pulse_out <= pulse_d;
      done      <= done_d;
    end
  end

endmodule
